uart_transmitter: RTL and testbench

Serial transmit half of a UART: accepts one 8-bit byte on a trigger and shifts it out on a single line as a standard asynchronous frame. The frame is one start bit (0), eight data bits LSB-first, an optional parity bit and one stop bit (1). It sits between a byte-producing host and the physical TX pin. It runs entirely on the system clock, with a parameterised clocks-per-bit divisor.

---
 rtl/uart_transmitter.sv | 150 +++++++++++++++
 tb/tb_uart_transmitter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: serial transmit half of a UART.
// Frames one byte as start(0), eight data bits LSB-first, an optional
// parity bit and one stop(1), each bit lasting CLKS_PER_BIT clocks.
// The tx line is driven straight from a flop, so no input reaches it
// combinationally.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 3,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       transmit_data,
    output logic       tx
);

    // A one-clock-per-bit divisor still needs a 1-bit timer to stay legal.
    localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         bit_index;
    logic [7:0]         shift;
    logic               parity_bit;
    logic               prev_trigger;

    logic start_req;
    logic bit_done;

    // Only a low-to-high transition of the trigger asks for a frame.
    assign start_req = transmit_data & ~prev_trigger;
    // Last clock of the current bit period.
    assign bit_done  = (timer == TIMER_LAST);

    // Trigger history; it keeps tracking the pin through reset so a trigger
    // held high across reset release does not count as a new edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <=, so every flop in
        // this file samples the values from before the clock edge.
        prev_trigger <= transmit_data;
    end

    // Frame sequencer: state, bit timer, data shifter and registered tx line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            timer      <= '0;
            bit_index  <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (start_req) begin
                        // Parity is taken from the byte as captured, since the
                        // shifter no longer holds it by the time it is sent.
                        shift      <= data;
                        parity_bit <= (^data) ^ PARITY_ODD;
                        timer      <= '0;
                        bit_index  <= '0;
                        tx         <= 1'b0;
                        state      <= START;
                    end
                end

                START: begin
                    if (bit_done) begin
                        timer     <= '0;
                        bit_index <= '0;
                        tx        <= shift[0];
                        state     <= DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        timer     <= '0;
                        shift     <= shift >> 1;
                        bit_index <= bit_index + 1'b1;
                        if (bit_index == 3'd7) begin
                            if (PARITY_EN) begin
                                tx    <= parity_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            // Next bit is the one about to be shifted into [0].
                            tx <= shift[1];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                PARITY: begin
                    if (bit_done) begin
                        timer <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        timer <= '0;
                        // The edge that ends the stop bit is also the first
                        // edge at which a new frame may be accepted.
                        if (start_req) begin
                            shift      <= data;
                            parity_bit <= (^data) ^ PARITY_ODD;
                            bit_index  <= '0;
                            tx         <= 1'b0;
                            state      <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed scoreboard bench for uart_transmitter.
// Stimulus pushes the hand-computed tx waveform of every frame it starts;
// a monitor per DUT pops a frame whenever its line drops low and compares
// the line cycle by cycle. One DUT uses defaults, the other even parity.
`timescale 1ns/1ps
module tb_uart_transmitter;

    localparam int C = 3;

    typedef struct {
        int          start_cyc;
        int          len;
        logic [63:0] seq;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_d = 8'h00;
    logic [7:0] data_p = 8'h00;
    logic       trig_d = 1'b0;
    logic       trig_p = 1'b0;
    logic       tx_d;
    logic       tx_p;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    frame_t q0[$];
    frame_t q1[$];

    uart_transmitter #(
        .CLKS_PER_BIT(C)
    ) u_dut_d (
        .clk(clk),
        .reset(reset),
        .data(data_d),
        .transmit_data(trig_d),
        .tx(tx_d)
    );

    uart_transmitter #(
        .CLKS_PER_BIT(C),
        .PARITY_EN(1'b1),
        .PARITY_ODD(1'b0)
    ) u_dut_p (
        .clk(clk),
        .reset(reset),
        .data(data_p),
        .transmit_data(trig_p),
        .tx(tx_p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic get_tx(input int which);
        return (which == 1) ? tx_p : tx_d;
    endfunction

    // Expand a per-slot bit list (slot 0 in bit 0) into a per-cycle waveform.
    function automatic frame_t make_frame(input int start, input logic [15:0] slots,
                                          input int nslots, input int len);
        frame_t f;
        f.start_cyc = start;
        f.len       = (len == 0) ? nslots * C : len;
        f.seq       = '0;
        for (int i = 0; i < nslots * C; i++) f.seq[i] = slots[i / C];
        return f;
    endfunction

    // Advance to just after the next n rising edges.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Raise the trigger now; the frame must start at the very next edge.
    task automatic fire(input int which, input logic [7:0] d, input logic [15:0] slots,
                        input int nslots, input int len);
        if (which == 1) begin
            data_p = d;
            trig_p = 1'b1;
            q1.push_back(make_frame(cyc + 1, slots, nslots, len));
        end else begin
            data_d = d;
            trig_d = 1'b1;
            q0.push_back(make_frame(cyc + 1, slots, nslots, len));
        end
    endtask

    task automatic run_monitor(input int which);
        frame_t f;
        bit     have;
        forever begin
            @(negedge clk);
            if (get_tx(which) === 1'b0) begin
                have = 1'b0;
                if (which == 0 && q0.size() > 0) begin
                    f    = q0.pop_front();
                    have = 1'b1;
                end else if (which == 1 && q1.size() > 0) begin
                    f    = q1.pop_front();
                    have = 1'b1;
                end
                if (!have) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_frame dut%0d: tx=0 at cycle %0d, expected idle 1",
                             which, cyc);
                    repeat (11 * C) @(negedge clk);
                end else begin
                    check_int($sformatf("start_cycle dut%0d", which), cyc, f.start_cyc);
                    for (int i = 0; i < f.len; i++) begin
                        if (i > 0) @(negedge clk);
                        check($sformatf("tx dut%0d offset %0d", which, i), get_tx(which), f.seq[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            run_monitor(0);
            run_monitor(1);
        join_none

        // Reset held two cycles with the trigger low.
        reset = 1'b0;
        step(2);
        check("reset_tx dut0", tx_d, 1'b1);
        check("reset_tx dut1", tx_p, 1'b1);
        reset = 1'b1;
        step(6);
        check("idle_tx dut0", tx_d, 1'b1);
        check("idle_tx dut1", tx_p, 1'b1);

        // 0x55 with a 10-cycle trigger hold: exactly one frame.
        fire(0, 8'h55, 16'b1010101010, 10, 0);
        step(10);
        trig_d = 1'b0;
        step(30);

        // 0xFF; data changed right after capture must not matter.
        fire(0, 8'hFF, 16'b1111111110, 10, 0);
        step(1);
        data_d = 8'h00;
        step(3);
        trig_d = 1'b0;
        step(32);

        // 0xA3 with a second rising edge at frame cycle 10: ignored.
        fire(0, 8'hA3, 16'b1101000110, 10, 0);
        step(3);
        trig_d = 1'b0;
        step(6);
        data_d = 8'h5A;
        trig_d = 1'b1;
        step(5);
        trig_d = 1'b0;
        step(30);

        // 0x00 aborted by reset during data bit 3 (frame offsets 12..14).
        // The trigger stays high through reset and release: no new frame.
        fire(0, 8'h00, 16'b1000000000, 10, 13);
        step(13);
        reset = 1'b0;
        step(1);
        check("abort_tx dut0", tx_d, 1'b1);
        check_int("abort_state dut0", int'(u_dut_d.state), 0);
        step(1);
        reset = 1'b1;
        step(6);
        check("held_trigger_idle dut0", tx_d, 1'b1);
        trig_d = 1'b0;
        step(2);
        fire(0, 8'h3C, 16'b1001111000, 10, 0);
        step(3);
        trig_d = 1'b0;
        step(34);

        // Even parity, 0x07: three ones give parity bit 1, 11 slots.
        fire(1, 8'h07, 16'b11000001110, 11, 0);
        step(3);
        trig_p = 1'b0;
        step(40);

        check_int("pending_frames dut0", q0.size(), 0);
        check_int("pending_frames dut1", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
